phys_reg_free_list: RTL

//  Circular free list of physical register tags feeding the rename stage's allocation port.
//  - Rename pops one tag per destination write.
//  - Commit/retire pushes back the superseded physical tag of each retired destination.
//  - Tag 0 is the permanent mapping of x0: never stored, never handed out.
//  - Sits between the retire logic (producer) and register_rename (consumer).
//  - alloc_valid_o drives rename's free-pointer qualifier.

---
 rtl/phys_reg_free_list.sv | 114 +++++++++++
 1 files changed

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags for the rename stage.
// Tag 0 (the fixed x0 mapping) is never stored or handed out; INIT fills tags 1..DEPTH after reset.
module phys_reg_free_list #(
    parameter  int O_COUNT = 128,
    localparam int TW      = $clog2(O_COUNT)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [TW-1:0] alloc_tag_o,
    output logic          alloc_valid_o,
    input  logic          alloc_ready_i,
    input  logic          release_valid_i,
    input  logic [TW-1:0] release_tag_i,
    output logic [TW-1:0] free_count_o,
    output logic          init_done_o,
    output logic          err_o
);

    localparam int DEPTH = O_COUNT - 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q;
    logic [TW-1:0] head_q;
    logic [TW-1:0] tail_q;
    logic [TW-1:0] initIdx_q;
    logic [TW-1:0] count_q;
    logic          initDone_q;
    logic          err_q;
    logic [TW-1:0] slots_q [DEPTH];

    logic          pop;
    logic          push;
    logic          full;
    logic          overflow;
    logic          tagNonZero;
    logic          releaseErr;
    logic [TW-1:0] headNext;
    logic [TW-1:0] tailNext;

    // DEPTH is generally not a power of two, so pointers wrap by explicit compare.
    always_comb begin
        headNext   = (head_q == TW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
        tailNext   = (tail_q == TW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
        pop        = alloc_valid_o & alloc_ready_i;
        full       = (count_q == TW'(DEPTH));
        overflow   = full & ~pop;
        tagNonZero = (release_tag_i != '0);
        push       = release_valid_i & (state_q == ST_RUN) & tagNonZero & ~overflow;
        releaseErr = release_valid_i &
                     ((state_q == ST_INIT) | ~tagNonZero | overflow);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            head_q     <= '0;
            tail_q     <= '0;
            initIdx_q  <= '0;
            count_q    <= '0;
            initDone_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_q | releaseErr;
            case (state_q)
                ST_INIT: begin
                    initIdx_q <= initIdx_q + 1'b1;
                    count_q   <= count_q + 1'b1;
                    if (initIdx_q == TW'(DEPTH - 1)) begin
                        state_q    <= ST_RUN;
                        tail_q     <= '0;
                        count_q    <= TW'(DEPTH);
                        initDone_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        head_q <= headNext;
                    end
                    if (push) begin
                        tail_q <= tailNext;
                    end
                    if (push && !pop) begin
                        count_q <= count_q + 1'b1;
                    end else if (pop && !push) begin
                        count_q <= count_q - 1'b1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Slot storage carries no reset; INIT rewrites every entry before it can be read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                slots_q[initIdx_q] <= initIdx_q + 1'b1;
            end else if (push) begin
                slots_q[tail_q] <= release_tag_i;
            end
        end
    end

    assign alloc_tag_o   = slots_q[head_q];
    assign alloc_valid_o = (state_q == ST_RUN) & (count_q != '0);
    assign free_count_o  = count_q;
    assign init_done_o   = initDone_q;
    assign err_o         = err_q;

endmodule
